// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler
// Single writer for the local branch predictor's pattern history table (PHT,
// 2-bit counters) and branch history table (BHT, per-entry history registers).
// After reset it sweeps every PHT entry to weakly-taken and clears the BHT.
// After that it retires buffered M-stage branch resolutions. Each retirement is
// one read-modify-write per cycle on both tables.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   branchM, takenM           resolved branch in M and its outcome
//   PHT_indexM, BHT_indexM    table indices used at fetch for that branch
//   pht_raddr / pht_rdata     RMW read port (async read data) of the PHT
//   bht_raddr / bht_rdata     RMW read port (async read data) of the BHT
//   pht_we/waddr/wdata        PHT write port
//   bht_we/waddr/wdata        BHT write port
//   init_busy                 initialisation sweep in progress
//   fifo_full                 pending-update FIFO holds FIFO_DEPTH entries
//   drop_cnt                  saturating count of updates lost to a full FIFO
//
// state  | meaning
// S_INIT | sweeping PHT/BHT to reset values, one entry per cycle; no retirement
// S_RUN  | retiring one buffered update per cycle while the FIFO is non-empty
module bp_update_scheduler #(
  parameter int PHT_INDEX_BITS = 7,
  parameter int BHT_INDEX_BITS = 3,
  parameter int BHR_BITS       = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      branchM,
  input  logic                      takenM,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
  input  logic [BHT_INDEX_BITS-1:0] BHT_indexM,
  output logic [PHT_INDEX_BITS-1:0] pht_raddr,
  input  logic [1:0]                pht_rdata,
  output logic [BHT_INDEX_BITS-1:0] bht_raddr,
  input  logic [BHR_BITS-1:0]       bht_rdata,
  output logic                      pht_we,
  output logic [PHT_INDEX_BITS-1:0] pht_waddr,
  output logic [1:0]                pht_wdata,
  output logic                      bht_we,
  output logic [BHT_INDEX_BITS-1:0] bht_waddr,
  output logic [BHR_BITS-1:0]       bht_wdata,
  output logic                      init_busy,
  output logic                      fifo_full,
  output logic [7:0]                drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PHT_INDEX_BITS + BHT_INDEX_BITS + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                    state;
  logic [PHT_INDEX_BITS-1:0] sweep_cnt;
  logic [ENT_W-1:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          count;
  logic [7:0]                drop_q;

  logic                      full;
  logic                      empty;
  logic                      deq;
  logic                      enq;
  logic                      drop;
  logic [ENT_W-1:0]          head;
  logic [PHT_INDEX_BITS-1:0] head_pht;
  logic [BHT_INDEX_BITS-1:0] head_bht;
  logic                      head_taken;

  // Counter encoding is Gray-ordered: SNT 00, WNT 01, WT 11, ST 10.
  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
    logic [1:0] n;
    case (c)
      2'b00:   n = t ? 2'b01 : 2'b00;
      2'b01:   n = t ? 2'b11 : 2'b00;
      2'b11:   n = t ? 2'b10 : 2'b01;
      default: n = t ? 2'b10 : 2'b11;
    endcase
    return n;
  endfunction

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign head_pht   = head[ENT_W-1 -: PHT_INDEX_BITS];
  assign head_bht   = head[BHT_INDEX_BITS:1];
  assign head_taken = head[0];

  // A dequeue in the same cycle frees a slot, so a full FIFO can still accept.
  assign deq  = !rst && (state == S_RUN) && !empty;
  assign enq  = !rst && branchM && (!full || deq);
  assign drop = !rst && branchM && full && !deq;

  assign pht_raddr = head_pht;
  assign bht_raddr = head_bht;
  assign init_busy = rst || (state == S_INIT);
  assign fifo_full = !rst && full;
  assign drop_cnt  = drop_q;

  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = '0;
    pht_wdata = 2'b00;
    bht_we    = 1'b0;
    bht_waddr = '0;
    bht_wdata = '0;
    if (!rst) begin
      if (state == S_INIT) begin
        pht_we    = 1'b1;
        pht_waddr = sweep_cnt;
        pht_wdata = 2'b11;
        // The BHT is smaller, so only the first 2^BHT_INDEX_BITS sweep steps touch it.
        bht_we    = ((sweep_cnt >> BHT_INDEX_BITS) == '0);
        bht_waddr = sweep_cnt[BHT_INDEX_BITS-1:0];
        bht_wdata = '0;
      end else if (deq) begin
        pht_we    = 1'b1;
        pht_waddr = head_pht;
        pht_wdata = next_ctr(pht_rdata, head_taken);
        bht_we    = 1'b1;
        bht_waddr = head_bht;
        bht_wdata = BHR_BITS'({bht_rdata, head_taken});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drop_q    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= {PHT_indexM, BHT_indexM, takenM};
  end

endmodule
